// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_pkg
//  Description : Shared helpers for the pipelined add/subtract unit.
//                  pipe_cfg_ok - legality check for WIDTH/STAGES pairs
//                  sat_value   - clamp constant used when saturating
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

    // Widest result the clamp helper can build.
    localparam int c_max_width = 64;

    // Every stage must own an equal, non-empty slice of the operands.
    function automatic bit pipe_cfg_ok(input int width, input int stages);
        return (width >= 2) && (width <= c_max_width) && (stages >= 1) &&
               ((width % stages) == 0);
    endfunction

    // Clamp value for an overflowing result, right-aligned in c_max_width bits.
    //   unsigned add -> all ones, unsigned sub -> zero
    //   signed positive overflow -> 0111..1, negative overflow -> 1000..0
    function automatic logic [c_max_width-1:0] sat_value(
        input int   width,
        input bit   signed_mode,
        input logic is_sub,
        input logic neg_ovf
    );
        logic [c_max_width-1:0] ones;
        logic [c_max_width-1:0] result;
        ones = {c_max_width{1'b1}} >> (c_max_width - width);
        if (signed_mode) begin
            if (neg_ovf) begin
                result = {{(c_max_width-1){1'b0}}, 1'b1} << (width - 1);
            end else begin
                result = ones >> 1;
            end
        end else begin
            result = is_sub ? '0 : ones;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_slice.sv
`default_nettype none
// ============================================================================
//  Module      : adder_slice
//  Description : One registered slice of the split carry chain.
//                Adds i_a + i_b + i_cin and registers sum and carry-out when
//                i_en is high.
//  Ports       : clk, rst_n (async, active-low), i_en,
//                i_a/i_b [SLICE_W], i_cin -> o_sum [SLICE_W], o_cout
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_slice #(
    parameter int SLICE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_cin,
    output logic [SLICE_W-1:0] o_sum,
    output logic               o_cout
);

    logic [SLICE_W:0] w_total;

    assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{SLICE_W{1'b0}}, i_cin};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sum  <= '0;
            o_cout <= 1'b0;
        end else if (i_en) begin
            o_sum  <= w_total[SLICE_W-1:0];
            o_cout <= w_total[SLICE_W];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_adder
//  Description : Pipelined add/subtract with valid/ready flow control,
//                optional saturation and signed/unsigned overflow reporting.
//                The carry chain is cut into STAGES registered slices; stage k
//                resolves slice k while lower slices travel as results and
//                upper slices travel as operands.
//  Ports       : clk, rst_n (async, active-low)
//                in_valid/in_ready, a, b, sub, sat  - operand stream
//                out_valid/out_ready, sum, carry, overflow - result stream
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int c_slice_w = WIDTH / STAGES;
    localparam int c_last    = STAGES - 1;
    localparam int c_msb     = WIDTH - 1;

    if (!pipe_cfg_ok(WIDTH, STAGES)) begin : g_cfg_bad
        $error("pipe_adder: WIDTH must be 2..64 and divisible by STAGES");
    end

    // ------------------------------------------------------------------------
    // Stage state. r_a[k] is the A-side vector entering stage k (results below
    // slice k, operand A from slice k up); r_b[k] is the effective B operand.
    // ------------------------------------------------------------------------
    logic                 w_adv;
    logic [WIDTH-1:0]     w_b_eff;
    logic [WIDTH-1:0]     r_a     [STAGES];
    logic [WIDTH-1:0]     r_b     [STAGES];
    logic [WIDTH-1:0]     w_a_out [STAGES];
    logic [c_slice_w-1:0] w_slice_sum [STAGES];
    logic [STAGES-1:0]    w_cout;
    logic [STAGES-1:0]    r_vld;
    logic [STAGES-1:0]    r_sub;
    logic [STAGES-1:0]    r_sat;

    // Global stall: the whole pipe moves only when the output can drain.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // Subtraction is a + ~b + 1; the +1 enters as the stage-0 carry-in.
    assign w_b_eff = sub ? ~b : b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_sub <= '0;
            r_sat <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
        end else if (w_adv) begin
            r_vld[0] <= in_valid;
            r_sub[0] <= sub;
            r_sat[0] <= sat;
            r_a[0]   <= a;
            r_b[0]   <= w_b_eff;
            for (int k = 1; k < STAGES; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_sub[k] <= r_sub[k-1];
                r_sat[k] <= r_sat[k-1];
                r_a[k]   <= w_a_out[k-1];
                r_b[k]   <= r_b[k-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // One registered slice per stage. The slice result register replaces
    // field k of the A-side vector on the way to the next stage.
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] c_mask =
            WIDTH'({c_slice_w{1'b1}}) << (k * c_slice_w);

        logic [c_slice_w-1:0] w_sa;
        logic [c_slice_w-1:0] w_sb;
        logic                 w_sc;

        if (k == 0) begin : g_first
            assign w_sa = a[0 +: c_slice_w];
            assign w_sb = w_b_eff[0 +: c_slice_w];
            assign w_sc = sub;
        end else begin : g_next
            assign w_sa = w_a_out[k-1][k*c_slice_w +: c_slice_w];
            assign w_sb = r_b[k-1][k*c_slice_w +: c_slice_w];
            assign w_sc = w_cout[k-1];
        end

        adder_slice #(
            .SLICE_W (c_slice_w)
        ) u_slice (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_en   (w_adv),
            .i_a    (w_sa),
            .i_b    (w_sb),
            .i_cin  (w_sc),
            .o_sum  (w_slice_sum[k]),
            .o_cout (w_cout[k])
        );

        assign w_a_out[k] = (r_a[k] & ~c_mask) |
                            (WIDTH'(w_slice_sum[k]) << (k * c_slice_w));
    end

    // ------------------------------------------------------------------------
    // Flags and saturation after the last slice. r_a/r_b of the last stage
    // still hold the operand sign bits, since their top slice was never
    // overwritten.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_sat_val;
    logic             w_c;
    logic             w_a_sign;
    logic             w_b_sign;
    logic             w_signed_ovf;

    assign w_res    = w_a_out[c_last];
    assign w_c      = w_cout[c_last];
    assign w_a_sign = r_a[c_last][c_msb];
    assign w_b_sign = r_b[c_last][c_msb];

    // Same-sign operands producing an opposite-sign result.
    assign w_signed_ovf = (w_a_sign == w_b_sign) && (w_res[c_msb] != w_a_sign);

    assign carry    = r_sub[c_last] ? ~w_c : w_c;
    assign overflow = SIGNED ? w_signed_ovf : carry;

    // Both operands negative is the only way to overflow negatively.
    assign w_sat_val = WIDTH'(sat_value(WIDTH, SIGNED, r_sub[c_last], w_a_sign));

    assign sum       = (r_sat[c_last] && overflow) ? w_sat_val : w_res;
    assign out_valid = r_vld[c_last];

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_adder
//  Description : Directed self-checking bench for pipe_adder (16 bit, 4
//                stages), one unsigned and one signed instance sharing the
//                same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_adder;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        sub       = 1'b0;
    logic        sat       = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a         = '0;
    logic [15:0] b         = '0;

    logic        u_in_ready, u_out_valid, u_carry, u_ovf;
    logic [15:0] u_sum;
    logic        s_in_ready, s_out_valid, s_carry, s_ovf;
    logic [15:0] s_sum;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(16), .STAGES(4), .SIGNED(1'b0)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (u_in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .sat       (sat),
        .out_valid (u_out_valid),
        .out_ready (out_ready),
        .sum       (u_sum),
        .carry     (u_carry),
        .overflow  (u_ovf)
    );

    pipe_adder #(.WIDTH(16), .STAGES(4), .SIGNED(1'b1)) s_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .sat       (sat),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .sum       (s_sum),
        .carry     (s_carry),
        .overflow  (s_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one beat, then wait (bounded) for the result; returns at the
    // negedge where out_valid is first seen, with lat = cycles after accept.
    task automatic do_beat(input logic [15:0] ta, input logic [15:0] tb_,
                           input logic tsub, input logic tsat, output int lat);
        @(negedge clk);
        a = ta; b = tb_; sub = tsub; sat = tsat; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (u_out_valid) break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] sa [16];
        logic [15:0] sb [16];
        logic        ssub [16];
        logic [15:0] exp_q [$];
        logic [15:0] e;
        logic [3:0]  mv;
        logic        madv;
        logic        prev_stall;
        logic [15:0] prev_sum;
        int          sent, got;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst_u_ovalid", u_out_valid, 0);
        chk("rst_u_iready", u_in_ready, 1);
        chk("rst_u_sum",    u_sum, 0);
        chk("rst_u_carry",  u_carry, 0);
        chk("rst_u_ovf",    u_ovf, 0);
        chk("rst_s_ovalid", s_out_valid, 0);
        chk("rst_s_sum",    s_sum, 0);
        chk("rst_s_ovf",    s_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- directed vectors ----------------
        do_beat(16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
        chk("v1_latency", lat, 4);
        chk("v1_sum",     u_sum, 16'h0100);
        chk("v1_carry",   u_carry, 0);
        chk("v1_ovf",     u_ovf, 0);

        do_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        chk("v2_latency", lat, 4);
        chk("v2_u_sum",   u_sum, 16'h0000);
        chk("v2_u_carry", u_carry, 1);
        chk("v2_u_ovf",   u_ovf, 1);
        chk("v2_s_sum",   s_sum, 16'h0000);
        chk("v2_s_carry", s_carry, 1);
        chk("v2_s_ovf",   s_ovf, 0);

        do_beat(16'hFFFF, 16'h0001, 1'b0, 1'b1, lat);
        chk("v3_u_sum",   u_sum, 16'hFFFF);
        chk("v3_u_carry", u_carry, 1);
        chk("v3_u_ovf",   u_ovf, 1);
        chk("v3_s_sum",   s_sum, 16'h0000);

        do_beat(16'h0003, 16'h0005, 1'b1, 1'b0, lat);
        chk("v4_u_sum",   u_sum, 16'hFFFE);
        chk("v4_u_carry", u_carry, 1);
        chk("v4_u_ovf",   u_ovf, 1);
        chk("v4_s_sum",   s_sum, 16'hFFFE);
        chk("v4_s_ovf",   s_ovf, 0);

        do_beat(16'h0003, 16'h0005, 1'b1, 1'b1, lat);
        chk("v5_u_sum",   u_sum, 16'h0000);
        chk("v5_u_carry", u_carry, 1);
        chk("v5_s_sum",   s_sum, 16'hFFFE);

        do_beat(16'h7FFF, 16'h0001, 1'b0, 1'b1, lat);
        chk("v6_s_sum",   s_sum, 16'h7FFF);
        chk("v6_s_ovf",   s_ovf, 1);
        chk("v6_s_carry", s_carry, 0);
        chk("v6_u_sum",   u_sum, 16'h8000);
        chk("v6_u_ovf",   u_ovf, 0);

        do_beat(16'h8000, 16'h0001, 1'b1, 1'b1, lat);
        chk("v7_s_sum",   s_sum, 16'h8000);
        chk("v7_s_ovf",   s_ovf, 1);
        chk("v7_s_carry", s_carry, 0);
        chk("v7_u_sum",   u_sum, 16'h7FFF);
        chk("v7_u_carry", u_carry, 0);

        // ---------------- stalled stream of 16 beats ----------------
        for (int i = 0; i < 16; i++) begin
            sa[i]   = 16'($urandom);
            sb[i]   = 16'($urandom);
            ssub[i] = 1'($urandom_range(0, 1));
        end
        mv = '0; prev_stall = 1'b0; prev_sum = '0; sent = 0; got = 0;
        for (int c = 0; c < 200 && got < 16; c++) begin
            @(negedge clk);
            out_ready = !(c == 3 || c == 4 || c == 5 || c == 9);
            sat = 1'b0;
            if (sent < 16) begin
                a = sa[sent]; b = sb[sent]; sub = ssub[sent]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            madv = !mv[3] || out_ready;
            chk("s_ovalid", u_out_valid, mv[3]);
            chk("s_iready", u_in_ready, madv);
            if (prev_stall) chk("s_hold", u_sum, prev_sum);
            if (u_out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                chk("s_result", u_sum, e);
                got++;
            end
            if (in_valid && u_in_ready) begin
                exp_q.push_back(sub ? (a - b) : (a + b));
                sent++;
            end
            prev_stall = u_out_valid && !out_ready;
            prev_sum   = u_sum;
            if (madv) mv = {mv[2:0], in_valid};
            @(posedge clk);
        end
        chk("s_received", got, 16);
        chk("s_sent", sent, 16);

        // ---------------- reset with beats in flight ----------------
        @(negedge clk);
        out_ready = 1'b1; sub = 1'b0; sat = 1'b0;
        a = 16'hFFFF; b = 16'h0002; in_valid = 1'b1;
        @(negedge clk);
        a = 16'h0100; b = 16'h0100;
        @(negedge clk);
        a = 16'h0200; b = 16'h0200;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("r_pre_ovalid", u_out_valid, 1);
        chk("r_pre_sum",    u_sum, 16'h0001);
        chk("r_pre_carry",  u_carry, 1);
        rst_n = 1'b0;
        #1;
        chk("r_ovalid", u_out_valid, 0);
        chk("r_sum",    u_sum, 0);
        chk("r_carry",  u_carry, 0);
        chk("r_ovf",    u_ovf, 0);
        chk("r_iready", u_in_ready, 1);
        @(negedge clk);
        chk("r_hold_iready", u_in_ready, 1);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("r_no_stale", u_out_valid, 0);
        end
        do_beat(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
        chk("r_latency", lat, 4);
        chk("r_sum_after", u_sum, 16'h2345);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined add/subtract unit with valid/ready flow control, optional saturation and signed/unsigned modes. It is the next generation of the team's single-cycle registered 4-bit adder. The carry chain is split into `STAGES` registered slices so that wide operands close timing. It sits between a producer and a consumer that both use valid/ready streams.

## Interface
- `WIDTH`, default 16: operand and result width. Must be ≥ 2 and divisible by `STAGES`.
- `STAGES`, default 4: number of pipeline stages, ≥ 1. Each stage handles a `WIDTH/STAGES`-bit slice.
- `SIGNED`, default 0: 0 treats operands as unsigned, 1 as two's complement. Affects only `overflow` and saturation.

- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  unit accepts a beat this cycle.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `sub`  in  1  0 computes a+b; 1 computes a−b.
- `sat`  in  1  1 clamps the result on overflow.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  WIDTH  result, wrapped or saturated.
- `carry`  out  1  add: carry-out of the MSB. Sub: borrow, i.e. 1 when a < b unsigned.
- `overflow`  out  1  `SIGNED`=0: equals `carry`. `SIGNED`=1: signed overflow.

## Operation
- Subtraction is a + ~b with carry-in 1. Internal carry-out C gives `carry` = C for add and `carry` = !C for sub.
- Stage k (0 = LSB) adds slice k plus the carry registered from stage k−1.
  - Slices below k are carried forward as already-computed results.
  - Slices above k are carried forward as delayed operands.
  - `sub`, `sat` and a per-stage valid bit travel with the data.
- The final stage computes `carry` and `overflow`. When `sat`=1 and `overflow`=1 it replaces `sum`:
  - unsigned add → all ones; unsigned sub → 0.
  - signed positive overflow → 0111…1; signed negative overflow → 1000…0.
- `carry` and `overflow` report the unsaturated arithmetic, whatever `sat` is.
- Flow control is a global stall:
  - `adv` = !`out_valid` || `out_ready`; `in_ready` = `adv`.
  - All stage registers load only when `adv`=1.
  - Bubbles propagate as invalid stages and are not collapsed.
- A beat is accepted when `in_valid` && `in_ready`. A result is consumed when `out_valid` && `out_ready`.

## Timing
- Latency: `STAGES` cycles from acceptance to `out_valid`, with no stall. `STAGES`=1 matches the legacy one-register behaviour.
- Throughput: one beat per cycle while `out_ready`=1.
- While stalled, `sum`, `carry` and `overflow` hold stable, and `out_valid` stays 1 until consumed.
- Accept and consume can occur in the same cycle at full pipeline occupancy; no beat is lost or duplicated.
- Reset, asserted at any time including mid-stream:
  - all stage valids, `out_valid`, `sum`, `carry` and `overflow` clear to 0 immediately;
  - in-flight beats are dropped;
  - `in_ready` reads 1 during and after reset.
- `in_ready` is combinational from `out_ready` and `out_valid` only, never from `in_valid`.
- `in_valid`, `a`, `b`, `sub` and `sat` are don't-care while `in_ready`=0.

## Structure
- Shared package `adder_pkg`:
  - function `sat_value(width, signed_mode, is_sub, neg_ovf)` returning the clamp constant;
  - localparam check helper asserting `WIDTH % STAGES == 0`.
- Sub-module `adder_slice`: registered `WIDTH/STAGES`-bit add with carry-in/out and enable. It is instantiated once per stage through a generate loop.
- Saturation and flag logic live in the top level, after the last slice.

## Test plan
Use `WIDTH`=16 and `STAGES`=4 unless stated otherwise.
- a=0x00FF, b=0x0001, add, `out_ready`=1 → `sum`=0x0100, `carry`=0, `out_valid` exactly 4 cycles after acceptance.
- Unsigned, a=0xFFFF, b=0x0001:
  - `sat`=0 → 0x0000, `carry`=1, `overflow`=1;
  - `sat`=1 → 0xFFFF with the same flags.
- Unsigned sub, a=0x0003, b=0x0005:
  - `sat`=0 → 0xFFFE, `carry`=1;
  - `sat`=1 → 0x0000.
- `SIGNED`=1:
  - 0x7FFF+0x0001, `sat`=1 → 0x7FFF, `overflow`=1;
  - 0x8000−0x0001, `sat`=1 → 0x8000, `overflow`=1;
  - 0xFFFF+0x0001 → 0x0000, `overflow`=0, `carry`=1.
- Stream 16 random back-to-back beats with `out_ready` low on cycles 3–5 and 9 → results in order, none lost or duplicated; outputs stable while stalled; `in_ready`=0 exactly while `out_valid`=1 and `out_ready`=0.
- Pulse `rst_n` low for 1 cycle with 3 beats in flight → all outputs 0 immediately; no stale results afterward; next accepted beat 0x1234+0x1111 returns 0x2345 after 4 cycles.
